// File: rtl/address_mux_pkg.sv
// Core address package.
// Shared by the PC, ALU, memory-port and load/store blocks of the core:
//   CORE_ADDR_W   - core address width
//   addr_t        - address type sized by CORE_ADDR_W
//   ADDR_SRC_INST - memory-port source tag for instruction fetch
//   ADDR_SRC_OP   - memory-port source tag for load/store operand
package address_mux_pkg;

  localparam int CORE_ADDR_W = 5;

  typedef logic [CORE_ADDR_W-1:0] addr_t;

  localparam logic ADDR_SRC_INST = 1'b0;
  localparam logic ADDR_SRC_OP   = 1'b1;

endpackage

// File: rtl/address_mux_align.sv
// addr_align_check: combinational alignment check.
// Flags an address whose low ALIGN_BITS bits are not all zero.
// Setting ALIGN_BITS to 0 disables the check, and the output is tied low.
// The load/store unit also uses this module.
// Ports:
//   addr_i       [WIDTH-1:0]  address under test
//   misaligned_o              1 = one or more low ALIGN_BITS bits are set
module addr_align_check #(
  parameter int WIDTH      = 5,
  parameter int ALIGN_BITS = 0
) (
  input  logic [WIDTH-1:0] addr_i,
  output logic             misaligned_o
);

  if (ALIGN_BITS >= WIDTH) begin : g_bad_align
    $error("addr_align_check: ALIGN_BITS must be < WIDTH");
  end

  if (ALIGN_BITS > 0) begin : g_chk
    assign misaligned_o = |addr_i[ALIGN_BITS-1:0];
  end else begin : g_nochk
    // The address is consumed only when the check is enabled.
    logic unused_addr;
    assign unused_addr  = ^addr_i;
    assign misaligned_o = 1'b0;
  end

endmodule

// File: rtl/address_mux.sv
// address_mux: registered address selector for the shared I/D memory port.
// Each enabled cycle, it captures either the fetch address or the
// load/store operand address.
// Alongside the address, it registers three status outputs:
//   - a source tag,
//   - a one-cycle source-switch pulse,
//   - an alignment flag.
// Ports:
//   clk, rst_n   clock; synchronous active-low reset
//   en_i         1 = capture new selection, 0 = hold (src_switch drops)
//   sel_i        0 = inst_addr_i, 1 = op_addr_i
//   inst_addr_i  fetch address (PC)
//   op_addr_i    operand address (ALU result)
//   addr_next_o  combinational preview of the selected address
//   addr_o       registered memory address
//   addr_src_o   sel value that produced addr_o
//   src_switch_o pulse: source changed on the last update
//   misaligned_o registered alignment flag for addr_o
module address_mux
  import address_mux_pkg::*;
#(
  parameter int               WIDTH      = 5,
  parameter logic [WIDTH-1:0] RESET_ADDR = '0,
  parameter int               ALIGN_BITS = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             sel_i,
  input  logic [WIDTH-1:0] inst_addr_i,
  input  logic [WIDTH-1:0] op_addr_i,
  output logic [WIDTH-1:0] addr_next_o,
  output logic [WIDTH-1:0] addr_o,
  output logic             addr_src_o,
  output logic             src_switch_o,
  output logic             misaligned_o
);

  logic [WIDTH-1:0] addr_d, addr_q;
  logic             src_d, src_q;
  logic             sw_d, sw_q;
  logic             mis_d, mis_q;
  logic             mis_next;

  assign addr_next_o = (sel_i == ADDR_SRC_OP) ? op_addr_i : inst_addr_i;

  addr_align_check #(
    .WIDTH      (WIDTH),
    .ALIGN_BITS (ALIGN_BITS)
  ) u_align (
    .addr_i       (addr_next_o),
    .misaligned_o (mis_next)
  );

  always_comb begin
    addr_d = addr_q;
    src_d  = src_q;
    mis_d  = mis_q;
    sw_d   = 1'b0;          // the pulse never survives a held cycle
    if (en_i) begin
      addr_d = addr_next_o;
      src_d  = sel_i;
      sw_d   = (sel_i != src_q);
      mis_d  = mis_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q <= RESET_ADDR;
      src_q  <= ADDR_SRC_INST;
      sw_q   <= 1'b0;
      mis_q  <= 1'b0;
    end else begin
      addr_q <= addr_d;
      src_q  <= src_d;
      sw_q   <= sw_d;
      mis_q  <= mis_d;
    end
  end

  assign addr_o       = addr_q;
  assign addr_src_o   = src_q;
  assign src_switch_o = sw_q;
  assign misaligned_o = mis_q;

endmodule

// File: tb/tb_address_mux.sv
module tb_address_mux;

  logic       clk = 1'b0;
  logic       rst_n, en, sel;
  logic [4:0] inst_addr, op_addr;

  logic [4:0] addr_next, addr;
  logic       addr_src, src_switch, misaligned;

  // Secondary instance: non-zero reset address, alignment check disabled.
  logic [4:0] b_addr_next, b_addr;
  logic       b_src, b_sw, b_mis;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  address_mux #(.WIDTH(5), .RESET_ADDR(5'b00000), .ALIGN_BITS(2)) dut (
    .clk(clk), .rst_n(rst_n), .en_i(en), .sel_i(sel),
    .inst_addr_i(inst_addr), .op_addr_i(op_addr),
    .addr_next_o(addr_next), .addr_o(addr), .addr_src_o(addr_src),
    .src_switch_o(src_switch), .misaligned_o(misaligned)
  );

  address_mux #(.WIDTH(5), .RESET_ADDR(5'b10101), .ALIGN_BITS(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .en_i(en), .sel_i(sel),
    .inst_addr_i(inst_addr), .op_addr_i(op_addr),
    .addr_next_o(b_addr_next), .addr_o(b_addr), .addr_src_o(b_src),
    .src_switch_o(b_sw), .misaligned_o(b_mis)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge; sample 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_regs(input string tag, input logic [4:0] a, input logic s,
                          input logic w, input logic m);
    check({tag, ".addr"}, {3'b0, addr}, {3'b0, a});
    check({tag, ".src"}, {7'b0, addr_src}, {7'b0, s});
    check({tag, ".sw"}, {7'b0, src_switch}, {7'b0, w});
    check({tag, ".mis"}, {7'b0, misaligned}, {7'b0, m});
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; sel = 1'b1; inst_addr = 5'b00000; op_addr = 5'b11111;
    #1;
    tick(); tick();
    chk_regs("reset", 5'b00000, 1'b0, 1'b0, 1'b0);
    check("reset.b_addr", {3'b0, b_addr}, 8'h15);
    check("reset.b_mis", {7'b0, b_mis}, 8'h0);
    check("reset.addr_next_comb", {3'b0, addr_next}, 8'h1f);

    // Instruction select
    rst_n = 1'b1; en = 1'b1; sel = 1'b0; inst_addr = 5'b10000; op_addr = 5'b11111;
    #1;
    check("isel.addr_next", {3'b0, addr_next}, 8'h10);
    tick();
    chk_regs("isel", 5'b10000, 1'b0, 1'b0, 1'b0);

    // Change the selected source
    inst_addr = 5'b10010; op_addr = 5'b01001;
    tick();
    chk_regs("ichg", 5'b10010, 1'b0, 1'b0, 1'b1);
    check("ichg.b_mis", {7'b0, b_mis}, 8'h0);
    check("ichg.b_addr", {3'b0, b_addr}, 8'h12);

    // Changing the unselected input has no effect
    op_addr = 5'b00000;
    #1;
    check("unsel.addr_next", {3'b0, addr_next}, 8'h12);
    tick();
    chk_regs("unsel", 5'b10010, 1'b0, 1'b0, 1'b1);

    // Switch to the operand source: a one-cycle pulse
    op_addr = 5'b01001; sel = 1'b1;
    tick();
    chk_regs("osel", 5'b01001, 1'b1, 1'b1, 1'b1);
    tick();
    chk_regs("osel2", 5'b01001, 1'b1, 1'b0, 1'b1);

    // Switch back, then hold
    sel = 1'b0;
    tick();
    chk_regs("back", 5'b10010, 1'b0, 1'b1, 1'b1);
    en = 1'b0; sel = 1'b1; op_addr = 5'b00111;
    #1;
    check("hold.addr_next", {3'b0, addr_next}, 8'h07);
    tick();
    chk_regs("hold", 5'b10010, 1'b0, 1'b0, 1'b1);
    tick();
    chk_regs("hold2", 5'b10010, 1'b0, 1'b0, 1'b1);

    // Alignment
    en = 1'b1; sel = 1'b0; inst_addr = 5'b10000;
    tick();
    chk_regs("align0", 5'b10000, 1'b0, 1'b0, 1'b0);
    inst_addr = 5'b10010;
    tick();
    chk_regs("align1", 5'b10010, 1'b0, 1'b0, 1'b1);

    // Mid-operation reset overrides a pending operand selection
    en = 1'b1; sel = 1'b1; op_addr = 5'b01001; rst_n = 1'b0;
    tick();
    chk_regs("midrst", 5'b00000, 1'b0, 1'b0, 1'b0);
    check("midrst.b_addr", {3'b0, b_addr}, 8'h15);
    check("midrst.b_sw", {7'b0, b_sw}, 8'h0);

    // First update after reset with sel=1 pulses src_switch
    rst_n = 1'b1;
    tick();
    chk_regs("first", 5'b01001, 1'b1, 1'b1, 1'b1);
    check("first.b_sw", {7'b0, b_sw}, 8'h1);
    check("first.b_src", {7'b0, b_src}, 8'h1);
    check("first.b_mis", {7'b0, b_mis}, 8'h0);
    check("first.b_addr_next", {3'b0, b_addr_next}, 8'h09);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/address_mux.md
Name: address_mux

Overview:
- Registered address selector for the shared instruction/data memory port of the multi-cycle RISC-V core.
- Each enabled cycle it picks the fetch address (inst_addr) or the load/store operand address (op_addr) under control of sel.
- It presents the chosen address to memory one cycle later, with source tag, source-switch pulse and alignment flag.

Parameters:
- WIDTH, 5, address width in bits for inst_addr, op_addr, addr, addr_next.
- RESET_ADDR, 0, value loaded into addr on reset (WIDTH bits, zero-extended/truncated).
- ALIGN_BITS, 0, number of low address bits that must be zero for an aligned access; 0 disables the check.

Ports:
- clk  in  1  single system clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset, sampled on rising edge of clk.
- en  in  1  load enable; 1 = register the new selection, 0 = hold all registered outputs.
- sel  in  1  source select; 0 = inst_addr, 1 = op_addr.
- inst_addr  in  WIDTH  instruction fetch address (PC).
- op_addr  in  WIDTH  data/operand address (ALU result).
- addr_next  out  WIDTH  combinational preview: sel ? op_addr : inst_addr.
- addr  out  WIDTH  registered memory address.
- addr_src  out  1  registered copy of sel that produced addr.
- src_switch  out  1  one-cycle pulse: registered source changed on this update.
- misaligned  out  1  registered; 1 when ALIGN_BITS>0 and low ALIGN_BITS of the captured address are not all zero.

Behaviour:
- Reset (rst_n=0 at rising edge, regardless of en): addr=RESET_ADDR, addr_src=0, src_switch=0, misaligned=0. addr_next stays combinational during reset.
- Normal update (rst_n=1, en=1), at each rising edge:
  - addr <= addr_next.
  - addr_src <= sel.
  - src_switch <= (sel != addr_src).
  - misaligned <= |addr_next[ALIGN_BITS-1:0] when ALIGN_BITS>0, else 0.
- Latency: a change on sel/inst_addr/op_addr appears on addr exactly one rising edge after it is sampled with en=1.
- Hold (rst_n=1, en=0): addr, addr_src and misaligned unchanged; src_switch forced to 0.
- src_switch is never high for two consecutive cycles unless sel toggles on two consecutive enabled edges.
- Changing the unselected input has no effect on addr_next or on any registered output.
- First enabled update after reset: src_switch=1 only if sel=1 (reset source is 0).
- Reset asserted mid-operation overrides en and any pending selection on that edge.
- No X-propagation masking: sel=X yields X on addr_next. Benches must drive sel to a known value.
- Purely combinational datapath between inputs and register: one WIDTH-bit 2:1 mux, comparator and OR-reduce. No arithmetic; widths never change.
- ALIGN_BITS must be < WIDTH; elaboration-time check (assertion/generate error) otherwise.

Decomposition:
- Shared package (core address package): ADDR_SRC_INST=1'b0 and ADDR_SRC_OP=1'b1 constants. Also an addr_t typedef sized by core address width, used by PC, ALU and memory blocks.
- One natural sub-module: addr_align_check (parameterised by WIDTH and ALIGN_BITS; input address, output misaligned bit). It is reused by the load/store unit.
- The mux and registers live in address_mux itself.

Test Plan:
- Reset: hold rst_n=0 two cycles with sel=1, op_addr=5'b11111 -> addr=5'b00000, addr_src=0, src_switch=0, misaligned=0.
- Instruction select: en=1, sel=0, inst_addr=5'b10000, op_addr=5'b11111 -> addr_next=5'b10000 immediately; addr=5'b10000 after one edge; src_switch=0.
- Input change on selected source: inst_addr=5'b10010, op_addr=5'b01001, sel=0 -> addr=5'b10010 next edge. Then sel=1 -> addr=5'b01001 next edge, addr_src=1, src_switch=1 for one cycle only.
- Switch back and hold: sel=0 -> addr=5'b10010 with src_switch=1. Then en=0, sel=1, op_addr=5'b00111 -> addr stays 5'b10010, addr_src stays 0, src_switch=0; addr_next=5'b00111.
- Alignment (ALIGN_BITS=2): sel=0, inst_addr=5'b10000 -> misaligned=0; inst_addr=5'b10010 -> misaligned=1 after one edge.
- Mid-operation reset: en=1, sel=1, op_addr=5'b01001 with rst_n=0 on same edge -> addr=RESET_ADDR, addr_src=0, src_switch=0.
